// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: sizing, ALU codes, the station write bundle
// and the per-operand source-resolution helper.
package tomasulo_pkg;

    localparam int unsigned NUM_RS = 8;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    typedef struct packed {
        logic             va;
        logic [TAG_W-1:0] qa;
        logic [XLEN-1:0]  data_a;
        logic             vb;
        logic [TAG_W-1:0] qb;
        logic [XLEN-1:0]  data_b;
        logic [4:0]       rd;
        logic [3:0]       alucode;
        logic [31:0]      pc;
    } rs_wr_t;

    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] q;
        logic [XLEN-1:0]  data;
    } operand_t;

    // r0 is hard-wired ready/zero; a pending source is rescued by a matching CDB broadcast.
    function automatic operand_t resolve_src(
        input logic [4:0]       r,
        input logic             pend,
        input logic [TAG_W-1:0] tag,
        input logic [XLEN-1:0]  rf,
        input logic             cdb_v,
        input logic [TAG_W-1:0] cdb_tag,
        input logic [XLEN-1:0]  cdb_data
    );
        operand_t res;
        res.v    = 1'b1;
        res.q    = tag;
        res.data = rf;
        if (r == 5'd0) begin
            res.q    = '0;
            res.data = '0;
        end else if (pend) begin
            if (cdb_v && (cdb_tag == tag)) begin
                res.data = cdb_data;
            end else begin
                res.v    = 1'b0;
                res.data = '0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_free_pick.sv
// Lowest-index free reservation-station entry finder.
module rs_free_pick
    import tomasulo_pkg::*;
(
    input  logic [NUM_RS-1:0] busy_i,
    output logic              found_o,
    output logic [TAG_W-1:0]  idx_o
);

    // Scan high to low so the lowest free index is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (!busy_i[i]) begin
                found_o = 1'b1;
                idx_o   = TAG_W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_dispatch.sv
// Reservation-station dispatch front end: entry allocation, register renaming
// through the register status table, and CDB snooping.
module rs_dispatch
    import tomasulo_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [3:0]        in_alucode,
    input  logic [XLEN-1:0]   rf_data_a,
    input  logic [XLEN-1:0]   rf_data_b,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [XLEN-1:0]   cdb_data,
    input  logic              rel_valid,
    input  logic [TAG_W-1:0]  rel_idx,
    output logic              rs_we,
    output logic [TAG_W-1:0]  rs_idx,
    output logic              rs_va,
    output logic [TAG_W-1:0]  rs_qa,
    output logic [XLEN-1:0]   rs_data_a,
    output logic              rs_vb,
    output logic [TAG_W-1:0]  rs_qb,
    output logic [XLEN-1:0]   rs_data_b,
    output logic [4:0]        rs_rd,
    output logic [3:0]        rs_alucode,
    output logic [31:0]       rs_pc
);

    logic [NUM_RS-1:0] busy_q, busy_d;
    logic [NREGS-1:0]  pend_q, pend_d;
    logic [TAG_W-1:0]  tag_q [NREGS];
    logic [TAG_W-1:0]  tag_d [NREGS];

    logic              free_found;
    logic [TAG_W-1:0]  free_idx;
    operand_t          src_a_c, src_b_c;
    rs_wr_t            wr_c;

    rs_free_pick u_free_pick (
        .busy_i  (busy_q),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    assign in_ready = reset & ~flush & free_found;
    assign rs_we    = in_valid & in_ready;
    assign rs_idx   = free_idx;

    // Sources see the table as it stood before this cycle's rename.
    always_comb begin
        src_a_c = resolve_src(in_rs, pend_q[in_rs], tag_q[in_rs], rf_data_a,
                              cdb_valid, cdb_tag, cdb_data);
        src_b_c = resolve_src(in_rt, pend_q[in_rt], tag_q[in_rt], rf_data_b,
                              cdb_valid, cdb_tag, cdb_data);
        wr_c         = '0;
        wr_c.va      = src_a_c.v;
        wr_c.qa      = src_a_c.q;
        wr_c.data_a  = src_a_c.data;
        wr_c.vb      = src_b_c.v;
        wr_c.qb      = src_b_c.q;
        wr_c.data_b  = src_b_c.data;
        wr_c.rd      = in_rd;
        wr_c.alucode = in_alucode;
        wr_c.pc      = in_pc;
    end

    assign rs_va      = wr_c.va;
    assign rs_qa      = wr_c.qa;
    assign rs_data_a  = wr_c.data_a;
    assign rs_vb      = wr_c.vb;
    assign rs_qb      = wr_c.qb;
    assign rs_data_b  = wr_c.data_b;
    assign rs_rd      = wr_c.rd;
    assign rs_alucode = wr_c.alucode;
    assign rs_pc      = wr_c.pc;

    // Next state: release, then allocate, CDB retire, then rename; flush overrides all.
    always_comb begin
        busy_d = busy_q;
        pend_d = pend_q;
        for (int r = 0; r < NREGS; r++) begin
            tag_d[r] = tag_q[r];
        end

        if (rel_valid) begin
            busy_d[rel_idx] = 1'b0;
        end
        if (rs_we) begin
            busy_d[free_idx] = 1'b1;
        end

        if (cdb_valid) begin
            for (int r = 1; r < NREGS; r++) begin
                if (pend_q[r] && (tag_q[r] == cdb_tag)) begin
                    pend_d[r] = 1'b0;
                end
            end
        end
        if (rs_we && (in_rd != 5'd0)) begin
            pend_d[in_rd] = 1'b1;
            tag_d[in_rd]  = free_idx;
        end

        if (flush) begin
            busy_d = '0;
            pend_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            pend_q <= '0;
            for (int r = 0; r < NREGS; r++) begin
                tag_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            for (int r = 0; r < NREGS; r++) begin
                tag_q[r] <= tag_d[r];
            end
        end
    end

endmodule

// File: doc/rs_dispatch.md
Name: rs_dispatch

Overview:
- Write-side front end of the reservation-station pool in the Tomasulo MIPS core.
- Accepts one decoded instruction per cycle and allocates a free station entry; the entry index is the renaming tag.
- Resolves each source operand to either a value or a producer tag, using a 32-entry register status table (RST).
- Snoops the common data bus (CDB) so that tags are retired from the RST and results are forwarded at dispatch time.

Parameters:
- NUM_RS, 8, number of reservation-station entries (power of 2).
- TAG_W, 3, log2(NUM_RS).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- flush  in  1  synchronous squash: clears RST and busy mask.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  dispatch possible this cycle.
- in_pc  in  32  instruction PC.
- in_rs  in  5  source A register.
- in_rt  in  5  source B register.
- in_rd  in  5  destination register.
- in_alucode  in  4  ALU operation.
- rf_data_a  in  XLEN  register file value of in_rs (combinational read).
- rf_data_b  in  XLEN  register file value of in_rt.
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_tag  in  TAG_W  producing entry.
- cdb_data  in  XLEN  result.
- rel_valid  in  1  station entry freed (issued to ALU).
- rel_idx  in  TAG_W  entry freed.
- rs_we  out  1  write strobe to the station pool.
- rs_idx  out  TAG_W  entry being written (= new tag).
- rs_va  out  1  operand A value valid.
- rs_qa  out  TAG_W  producer tag for A when rs_va=0.
- rs_data_a  out  XLEN  operand A value.
- rs_vb, rs_qb, rs_data_b  out  1/TAG_W/XLEN  same for B.
- rs_rd  out  5  destination.
- rs_alucode  out  4  ALU operation.
- rs_pc  out  32  PC.

Behaviour:
- State: busy[NUM_RS] mask; RST[1..31] = {pend, tag}. Register 0 has no RST entry and always reads as ready with value 0.
- Reset (async, low): busy=0, all pend=0. While reset is low: in_ready=0, rs_we=0.
- Outputs are combinational from current state and inputs. rs_we = in_valid & in_ready. Dispatch latency is 0; the station pool captures at the same clk edge. When rs_we=0, the data outputs are don't-care but must hold no X on rs_we.
- in_ready = ~flush & (busy != all ones).
- Allocation: rs_idx = lowest index with busy=0. On the edge, busy[rs_idx] is set.
- Release: rel_valid clears busy[rel_idx] on the edge. The cleared entry is not allocatable until the next cycle.
- Release and allocation of different entries in the same cycle: both take effect.
- rel_valid on a non-busy entry: no effect.
- Source resolution (per operand, using the RST state before this cycle's update):
  - reg 0: v=1, data=0.
  - not pend: v=1, data=rf_data.
  - pend and cdb_valid and cdb_tag==RST.tag: v=1, data=cdb_data.
  - otherwise: v=0, q=RST.tag, data=0.
- Destination: on dispatch with in_rd!=0, RST[in_rd] <= {1, rs_idx} on the edge. A source equal to in_rd still sees the old mapping.
- CDB retire: on the edge, every RST entry with pend=1 and tag==cdb_tag gets pend=0. When a dispatch writes the same register in that cycle, the dispatch wins.
- flush: busy=0 and all pend=0 on the edge. flush overrides dispatch and release. in_ready=0 in that cycle.
- Reset mid-operation: state is cleared immediately; a dispatch in progress is lost.

Decomposition:
- Shared package (tomasulo_pkg): NUM_RS, TAG_W, XLEN, ALU code constants, and the RS write-bundle struct {va, qa, data_a, vb, qb, data_b, rd, alucode, pc}.
- One sub-module: rs_free_pick, a lowest-zero priority encoder giving {found, idx}.
- The RST lives inline in rs_dispatch.

Test Plan:
- Reset then dispatch add r3,r1,r2 with rf_data_a=5, rf_data_b=7 -> rs_we=1, rs_idx=0, va=vb=1, data 5/7; RST[3] becomes {1,0}.
- Next, dispatch sub r4,r3,r3 -> rs_idx=1, va=vb=0, qa=qb=0. Then CDB tag 0 data 0x55 -> RST[3].pend clears; a third instruction reading r3 gets va=1 from rf.
- Dispatch reading r3 while cdb_valid, tag 0, data 0x99 in the same cycle -> va=1, data_a=0x99.
- Eight dispatches with no release -> in_ready=0 on the 9th cycle. rel_valid idx 5 -> in_ready returns next cycle and rs_idx=5.
- Dispatch add r3,r3,r0 while RST[3]={1,2} -> qa=2, vb=1, data_b=0; RST[3] becomes {1,new}. Simultaneous CDB tag 2 does not clear it.
- flush with 4 busy entries and pending RST -> next cycle rs_idx=0, all sources read from rf. Async reset low mid-burst -> rs_we=0 immediately.
